rr_arbiter: RTL

RR_ARBITER -- requirements
Module: rr_arbiter

---
 rtl/rr_arbiter_pkg.sv | 12 +
 rtl/rr_arbiter_if.sv | 28 ++
 rtl/rr_pick.sv | 37 +++
 rtl/rr_arbiter.sv | 98 +++++++++
 4 files changed

// File: rtl/rr_arbiter_pkg.sv
// Shared types and constants for the round-robin arbiter.
// Holds the FSM state encoding and the default requester count.
package rr_arbiter_pkg;

    localparam int N_DEFAULT = 8;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/rr_arbiter_if.sv
// Request/grant bundle between the requesters and the arbiter.
// Ports: req, done (requester side) / grant, gnt_valid (arbiter side).
import rr_arbiter_pkg::*;

interface rr_arbiter_if #(
    parameter int N = N_DEFAULT
);

    logic [N-1:0] req;
    logic         done;
    logic [N-1:0] grant;
    logic         gnt_valid;

    modport master (
        output req,
        output done,
        input  grant,
        input  gnt_valid
    );

    modport slave (
        input  req,
        input  done,
        output grant,
        output gnt_valid
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational wrap-around search: first set req bit at or above ptr.
// Ports: req, ptr in; onehot, idx, any out.
import rr_arbiter_pkg::*;

module rr_pick #(
    parameter int N = N_DEFAULT,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] onehot,
    output logic [W-1:0] idx,
    output logic         any
);

    logic found;

    // k is reduced modulo N by a single subtract, so the wrap is
    // exact for non-power-of-two N.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            int k;
            k = int'(ptr) + i;
            if (k >= N) k = k - N;
            if (!found && req[k]) begin
                found = 1'b1;
                idx   = W'(k);
            end
        end
    end

    assign any    = found;
    assign onehot = found ? (N'(1) << idx) : '0;

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with registered one-hot grant held until release.
// Ports: clk, rst_n (async, active-low); bus (slave: req, done, grant, gnt_valid).
import rr_arbiter_pkg::*;

module rr_arbiter #(
    parameter int N = N_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    rr_arbiter_if.slave  bus
);

    localparam int W = $clog2(N);

    state_t       state_q, state_d;
    logic [W-1:0] ptr_q, ptr_d;
    logic [W-1:0] hold_q, hold_d;
    logic [N-1:0] grant_q, grant_d;
    logic         valid_q, valid_d;

    logic [N-1:0] pick_oh;
    logic [W-1:0] pick_idx;
    logic         pick_any;
    logic         release_now;

    rr_pick #(
        .N (N),
        .W (W)
    ) u_pick (
        .req    (bus.req),
        .ptr    (ptr_q),
        .onehot (pick_oh),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // Holder finishes, or simply stops asking.
    assign release_now = bus.done || !bus.req[hold_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            hold_q  <= '0;
            grant_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            grant_q <= grant_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (pick_any) state_d = BUSY;
            BUSY:    if (release_now) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A release always lands in IDLE, so the next grant is at least
    // one cycle later and uses the advanced pointer.
    always_comb begin
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        grant_d = grant_q;
        valid_d = valid_q;
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_d = pick_oh;
                    hold_d  = pick_idx;
                    valid_d = 1'b1;
                end
            end
            BUSY: begin
                if (release_now) begin
                    grant_d = '0;
                    valid_d = 1'b0;
                    if (hold_q == W'(N - 1)) ptr_d = '0;
                    else                      ptr_d = hold_q + W'(1);
                end
            end
            default: begin
                grant_d = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    assign bus.grant     = grant_q;
    assign bus.gnt_valid = valid_q;

endmodule
